// File: rtl/ll_fifo_pkg.sv
// Shared definitions for the linked_list_fifo slice: sel width helper and buffer depth.
package ll_fifo_pkg;

  localparam int BUF_DEPTH = 2;

  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ll_fifo_drain_arb_if.sv
// Drain-stage bus: FIFO-facing pop side plus the valid/ready output side.
interface ll_fifo_drain_arb_if
  import ll_fifo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int NUM_FIFOS = 1
);
  localparam int SEL_WIDTH = sel_width(NUM_FIFOS);

  logic [NUM_FIFOS-1:0] empty;
  logic [WIDTH-1:0]     fifo_data;
  logic                 pop;
  logic [SEL_WIDTH-1:0] pop_sel;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_WIDTH-1:0] out_sel;

  modport master (
    input  empty, fifo_data, out_ready,
    output pop, pop_sel, out_valid, out_data, out_sel
  );

  modport slave (
    output empty, fifo_data, out_ready,
    input  pop, pop_sel, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/ll_rr_arbiter.sv
// Combinational round-robin pick: first requesting index at or after ptr, wrapping.
module ll_rr_arbiter
  import ll_fifo_pkg::*;
#(
  parameter int NUM_FIFOS = 1,
  localparam int SEL_WIDTH = sel_width(NUM_FIFOS)
) (
  input  logic [NUM_FIFOS-1:0] req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [SEL_WIDTH-1:0] grant,
  output logic                 any
);

  logic [SEL_WIDTH:0]   sum;
  logic [SEL_WIDTH-1:0] idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
      sum = {1'b0, ptr} + (SEL_WIDTH+1)'(i);
      if (sum >= (SEL_WIDTH+1)'(NUM_FIFOS)) sum = sum - (SEL_WIDTH+1)'(NUM_FIFOS);
      idx = sum[SEL_WIDTH-1:0];
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/ll_fifo_drain_arb.sv
// Round-robin dequeue stage for linked_list_fifo with a 2-entry valid/ready output buffer.
// Define LL_DRAIN_ASSERT_EN to add the formal/simulation checks.
module ll_fifo_drain_arb
  import ll_fifo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int NUM_FIFOS = 1,
  localparam int SEL_WIDTH = sel_width(NUM_FIFOS)
) (
  input logic                clk,
  input logic                rst,
  input logic                en,
  ll_fifo_drain_arb_if.master bus
);

  // Entry width depends on module parameters, so the type is declared here.
  typedef struct packed {
    logic [SEL_WIDTH-1:0] sel;
    logic [WIDTH-1:0]     data;
  } ll_entry_t;

  ll_entry_t            buf_mem [BUF_DEPTH];
  logic [1:0]           count;
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [SEL_WIDTH-1:0] rr_ptr;
  logic [SEL_WIDTH-1:0] grant;
  logic [NUM_FIFOS-1:0] eligible;
  logic                 any;
  logic                 pop;
  logic                 drain;

  assign eligible = ~bus.empty;

  ll_rr_arbiter #(.NUM_FIFOS(NUM_FIFOS)) u_arb (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (grant),
    .any   (any)
  );

  // rst gates pop so the strobe is low for the whole asynchronous reset window.
  assign pop           = rst & en & any & (count < 2'(BUF_DEPTH));
  assign drain         = bus.out_valid & bus.out_ready;
  assign bus.pop       = pop;
  assign bus.pop_sel   = pop ? grant : '0;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_data  = buf_mem[rd_ptr].data;
  assign bus.out_sel   = buf_mem[rd_ptr].sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      rr_ptr <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
    end else begin
      if (pop) begin
        buf_mem[wr_ptr] <= '{sel: grant, data: bus.fifo_data};
        wr_ptr          <= ~wr_ptr;
        rr_ptr          <= (int'(grant) == NUM_FIFOS - 1) ? '0 : grant + 1'b1;
      end
      if (drain) rd_ptr <= ~rd_ptr;
      case ({pop, drain})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef LL_DRAIN_ASSERT_EN
  a_no_empty_pop: assert property (@(posedge clk) disable iff (!rst)
    !(pop && bus.empty[bus.pop_sel]));
  a_count_max: assert property (@(posedge clk) disable iff (!rst)
    count <= 2'(BUF_DEPTH));
  a_stall_stable: assert property (@(posedge clk) disable iff (!rst)
    (bus.out_valid && !bus.out_ready) |=> ($stable(bus.out_data) && $stable(bus.out_sel)));
  m_consumer: assume property (@(posedge clk) disable iff (!rst)
    $stable(bus.out_valid) || $stable(bus.out_ready));
`else
`endif

endmodule

// File: tb/tb_ll_fifo_drain_arb.sv
// Directed bench for ll_fifo_drain_arb (WIDTH=4, NUM_FIFOS=4) with a FIFO model and scoreboard.
module tb_ll_fifo_drain_arb;

  localparam int W  = 4;
  localparam int NF = 4;
  localparam int D  = 16;

  logic clk = 1'b0;
  logic rst;
  logic en;

  ll_fifo_drain_arb_if #(.WIDTH(W), .NUM_FIFOS(NF)) bus ();

  ll_fifo_drain_arb #(.WIDTH(W), .NUM_FIFOS(NF)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural linked_list_fifo: per-queue circular arrays.
  logic [W-1:0] fmem [NF][D];
  int           fhd  [NF];
  int           fcnt [NF];

  always_comb begin
    for (int i = 0; i < NF; i++) bus.empty[i] = (fcnt[i] == 0);
    bus.fifo_data = fmem[bus.pop_sel][fhd[bus.pop_sel]];
  end

  int          tests = 0;
  int          fails = 0;
  logic [5:0]  sb [$];
  int          m_count;
  int          m_rr;
  bit          m_pop, m_drain, act_pop;
  logic [1:0]  act_sel;
  int          pops_q [NF];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int q, input logic [W-1:0] v);
    fmem[q][(fhd[q] + fcnt[q]) % D] = v;
    fcnt[q]++;
  endtask

  task automatic check();
    logic [5:0] e;
    bit         exp_pop;
    int         exp_sel;
    if (!rst) begin
      m_count = 0;
      m_rr    = 0;
      sb.delete();
    end
    chk("out_valid", bus.out_valid, m_count != 0);
    m_drain = (m_count != 0) && bus.out_ready;
    if (m_drain) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("out_sel", bus.out_sel, e[5:4]);
        chk("out_data", bus.out_data, e[3:0]);
      end
    end
    exp_pop = 1'b0;
    exp_sel = 0;
    if (rst && en && m_count < 2) begin
      for (int k = 0; k < NF; k++) begin
        int idx = (m_rr + k) % NF;
        if (!exp_pop && fcnt[idx] != 0) begin
          exp_pop = 1'b1;
          exp_sel = idx;
        end
      end
    end
    chk("pop", bus.pop, exp_pop);
    chk("pop_sel", bus.pop_sel, exp_pop ? exp_sel : 0);
    if (exp_pop) begin
      sb.push_back({2'(exp_sel), fmem[exp_sel][fhd[exp_sel]]});
      m_rr = (exp_sel == NF - 1) ? 0 : exp_sel + 1;
    end
    m_pop   = exp_pop;
    act_pop = bus.pop;
    act_sel = bus.pop_sel;
  endtask

  task automatic retire();
    if (rst) m_count = m_count + int'(m_pop) - int'(m_drain);
    if (act_pop) begin
      if (fcnt[act_sel] == 0) chk("pop_of_empty", 1, 0);
      else begin
        fhd[act_sel] = (fhd[act_sel] + 1) % D;
        fcnt[act_sel]--;
        pops_q[act_sel]++;
      end
    end
  endtask

  task automatic tick();
    #1;
    check();
    @(posedge clk);
    #1;
    retire();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [W-1:0] held;

  initial begin
    for (int q = 0; q < NF; q++) begin
      fhd[q] = 0; fcnt[q] = 0; pops_q[q] = 0;
      for (int d = 0; d < D; d++) fmem[q][d] = '0;
    end
    m_count = 0; m_rr = 0; m_pop = 0; m_drain = 0; act_pop = 0; act_sel = '0;
    rst = 1'b0; en = 1'b1; bus.out_ready = 1'b1;

    // Reset held with every queue non-empty.
    for (int q = 0; q < NF; q++) begin
      load(q, 4'(q));
      load(q, 4'(q + 8));
    end
    ticks(3);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_sel", bus.out_sel, 0);

    // Release: round-robin 0,1,2,3,0,... one pop per cycle.
    rst = 1'b1;
    #1;
    chk("first_pop", bus.pop, 1);
    chk("first_sel", bus.pop_sel, 0);
    ticks(11);
    chk("rr_q0_pops", pops_q[0], 2);
    chk("rr_q3_pops", pops_q[3], 2);

    // Skip empties: only queues 0 and 2 hold words, rr_ptr is back at 0.
    for (int q = 0; q < NF; q++) pops_q[q] = 0;
    load(0, 4'h1); load(0, 4'h2);
    load(2, 4'h3); load(2, 4'h4);
    ticks(6);
    chk("skip_q1", pops_q[1], 0);
    chk("skip_q3", pops_q[3], 0);
    chk("skip_q0", pops_q[0], 2);

    // Backpressure: two pops fill the buffer, then pop stays low.
    bus.out_ready = 1'b0;
    load(0, 4'h5); load(1, 4'h6); load(2, 4'h7);
    tick();
    held = sb[0][3:0];
    ticks(3);
    chk("bp_pop_low", bus.pop, 0);
    chk("bp_fifo_left", fcnt[0] + fcnt[1] + fcnt[2], 1);
    chk("bp_hold_data", bus.out_data, held);
    tick();
    chk("bp_hold_again", bus.out_data, held);
    bus.out_ready = 1'b1;
    ticks(5);

    // Last word of queue 2 is popped once only.
    bus.out_ready = 1'b0;
    for (int q = 0; q < NF; q++) pops_q[q] = 0;
    load(2, 4'hA);
    ticks(3);
    chk("lw_pops", pops_q[2], 1);
    chk("lw_empty", bus.empty[2], 1);
    chk("lw_data", bus.out_data, 4'hA);
    chk("lw_sel", bus.out_sel, 2);
    bus.out_ready = 1'b1;
    ticks(2);

    // Sustained throughput with all queues loaded.
    for (int q = 0; q < NF; q++) pops_q[q] = 0;
    for (int q = 0; q < NF; q++) for (int k = 0; k < 3; k++) load(q, 4'(q * 3 + k));
    ticks(14);
    chk("tp_total", pops_q[0] + pops_q[1] + pops_q[2] + pops_q[3], 12);

    // Drain disabled.
    en = 1'b0;
    load(1, 4'hC);
    ticks(2);
    en = 1'b1;
    ticks(3);

    // Mid-operation reset with a full buffer.
    bus.out_ready = 1'b0;
    load(0, 4'hD); load(1, 4'hE); load(3, 4'hF);
    ticks(3);
    chk("mid_full_valid", bus.out_valid, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    ticks(2);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    ticks(6);
    chk("mid_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
